// File: rtl/mips_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_lite_pkg
// Brief    : Shared constants, opcodes and IFU state encoding for MIPS-lite.
// Revision : 1.0
// ============================================================================
package mips_lite_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Opcodes shared with the control decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } ifu_state_e;

endpackage
`default_nettype wire

// File: rtl/ifu_npc.sv
`default_nettype none
// ============================================================================
// Module   : npc
// Brief    : Combinational next-PC: sequential, beq branch or j jump target.
// Revision : 1.0
// ============================================================================
module npc
    import mips_lite_pkg::*;
(
    input  logic [31:0] inst_pc,
    input  logic [25:0] inst_field,
    input  logic        br_taken,
    input  logic        jmp,
    output logic [31:0] next_pc
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;

    assign w_pc4    = inst_pc + 32'd4;
    assign w_br_off = {{14{inst_field[15]}}, inst_field[15:0], 2'b00};

    // Jump has priority over a simultaneously reported branch
    always_comb begin
        next_pc = w_pc4;
        if (jmp) begin
            next_pc = {w_pc4[31:28], inst_field, 2'b00};
        end else if (br_taken) begin
            next_pc = w_pc4 + w_br_off;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module   : ifu
// Brief    : Single-outstanding instruction fetch unit with PC and FSM.
// Revision : 1.0
// ============================================================================
module ifu
    import mips_lite_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ack,
    input  logic        br_taken,
    input  logic        jmp,
    input  logic        halt
);

    ifu_state_e  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_req;
    logic        r_valid;
    logic [31:0] w_npc;

    npc u_npc (
        .inst_pc    (r_inst_pc),
        .inst_field (r_inst[25:0]),
        .br_taken   (br_taken),
        .jmp        (jmp),
        .next_pc    (w_npc)
    );

    // req/valid are registered alongside the state so no input reaches them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_inst    <= 32'd0;
            r_inst_pc <= 32'd0;
            r_req     <= 1'b1;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_inst    <= imem_rdata;
                        r_inst_pc <= r_pc;
                        r_state   <= ST_HOLD;
                        r_req     <= 1'b0;
                        r_valid   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (inst_ack) begin
                        r_pc    <= w_npc;
                        r_valid <= 1'b0;
                        if (halt) begin
                            r_state <= ST_HALT;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= ST_FETCH;
                            r_req   <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst_valid = r_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the MIPS-lite core: owns the program counter, fetches 32-bit instruction words from instruction memory over a ready-based handshake, and presents one instruction at a time to the decoder/control stage. The consumer acknowledges each instruction and returns the branch/jump decision for it; the IFU computes the next PC (sequential, `beq` branch, `j` jump) from that decision and fetches again. No prefetch, no speculation: exactly one instruction is in flight at any time.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request; held high with stable `imem_addr` until accepted.
- `imem_addr`  out  32  byte address of word to fetch (bits [1:0] always 0).
- `imem_ready`  in  1  memory accepts request and drives `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word, valid only when `imem_req & imem_ready`.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a fetched instruction.
- `inst`  out  32  current instruction word.
- `inst_pc`  out  32  address of `inst`.
- `inst_ack`  in  1  consumer retires `inst` this cycle; ignored when `inst_valid` low.
- `br_taken`  in  1  with `inst_ack`: retired instruction is a taken `beq`.
- `jmp`  in  1  with `inst_ack`: retired instruction is `j`.
- `halt`  in  1  with `inst_ack`: stop fetching after this instruction.

## Operation
- States: FETCH, HOLD, HALT. Reset state FETCH, `pc = RESET_PC`.
- FETCH: `imem_req = 1`, `imem_addr = pc`. On `imem_ready`: capture `imem_rdata` into `inst`, `pc` into `inst_pc`, go HOLD. Else stay.
- HOLD: `inst_valid = 1`, `imem_req = 0`. On `inst_ack`: `pc <= npc`; go HALT if `halt`, else FETCH. Else stay, outputs stable.
- HALT: `imem_req = 0`, `inst_valid = 0`; left only by reset.
- Next-PC, computed from `inst_pc` and `inst`, all 32-bit modulo 2^32:
  - `pc4 = inst_pc + 4`.
  - `jmp`: `{pc4[31:28], inst[25:0], 2'b00}`.
  - else `br_taken`: `pc4 + (sign_ext(inst[15:0]) << 2)`.
  - else `pc4`.
- `jmp` and `br_taken` both high: `jmp` wins. `halt` together with `jmp`/`br_taken`: `pc` still updated, then HALT.
- Wrap-around: `32'hFFFF_FFFC + 4 = 32'h0000_0000`; no fault.
- `br_taken`, `jmp`, `halt` are don't-care unless `inst_valid & inst_ack`.

## Timing
- Reset values: `imem_req = 1` (FETCH), `imem_addr = RESET_PC`, `inst_valid = 0`, `inst = 0`, `inst_pc = 0`.
- Reset asserted mid-operation (any state, any handshake): immediate return to reset values; outstanding request abandoned, memory must tolerate `imem_req` dropping/restarting.
- `imem_req`, `imem_addr`, `inst_valid` are decoded from state/registers only (no combinational path from any input).
- Latency: `imem_ready` sampled high in cycle N -> `inst_valid` high in N+1. `inst_ack` in cycle M -> `imem_req` with new address in M+1.
- Zero-wait memory and immediate ack: one instruction per 2 cycles.
- `imem_ready` while `imem_req` low: ignored.

## Structure
- Shared package `mips_lite_pkg`: `RESET_PC` default, opcode constants (`OP_BEQ = 6'h04`, `OP_J = 6'h02`, etc.) shared with the control decoder, IFU state enum.
- Sub-module `npc`: combinational next-PC calculation (`inst_pc`, `inst`, `br_taken`, `jmp` -> `npc`); IFU holds FSM and registers.

## Test plan
- Reset release, memory ready same cycle, ack immediately, no branch: `imem_addr` sequence `0x3000, 0x3004, 0x3008`; `inst_valid` toggles every other cycle.
- `inst_pc = 0x3010`, `inst = 0x1000_FFFE` (beq, offset -2), ack with `br_taken = 1` -> next `imem_addr = 0x300C`; same with offset `+3` -> `0x3020`.
- `inst_pc = 0x3010`, `inst = 0x0800_0C00` (j), ack with `jmp = 1`, `br_taken = 1` -> next `imem_addr = 0x0000_3000`.
- Memory stalls 3 cycles (`imem_ready = 0`): `imem_req` high and `imem_addr` stable all 4 cycles; consumer withholds ack 5 cycles: `inst`/`inst_pc` stable, no request issued.
- Ack with `halt = 1` at `inst_pc = 0x3008` -> `imem_req` and `inst_valid` stay 0 for 20 cycles; assert `rst` -> `imem_req = 1`, `imem_addr = 0x3000` in the same cycle.
- `rst` asserted while in FETCH with `imem_ready = 0` and while in HOLD -> all outputs at reset values immediately; fetch restarts at `RESET_PC`; PC `0xFFFF_FFFC` sequential -> next `imem_addr = 0x0000_0000`.
